// File: rtl/dtb_pkg.sv
// Shared trace-buffer constants and types.
// Used by the Logger, the RAM scheduler and the host interface.
package dtb_pkg;

   localparam int TRB_WIDTH      = 16;
   localparam int TRB_ADDR_WIDTH = 8;
   localparam int TRB_HOST_SLOTS = 2;

   typedef enum logic [1:0] {
      SLOT_LOG_WR = 2'd0,
      SLOT_LOG_RD = 2'd1,
      SLOT_HOST   = 2'd2
   } slot_role_t;

endpackage

// File: rtl/trb_slot_counter.sv
// Free-running frame counter for the trace RAM time-division schedule.
// Reports the role of the current cycle; it does not depend on the enable.
module trb_slot_counter
   import dtb_pkg::*;
#(
   parameter int NSLOT = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   output slot_role_t o_role
);

   localparam int SW = $clog2(NSLOT);

   logic [SW-1:0] r_slot;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_slot <= '0;
      end else if (r_slot == SW'(NSLOT - 1)) begin
         r_slot <= '0;
      end else begin
         r_slot <= r_slot + SW'(1);
      end
   end

   always_comb begin
      o_role = SLOT_HOST;
      unique case (1'b1)
         (r_slot == SW'(0)): o_role = SLOT_LOG_WR;
         (r_slot == SW'(1)): o_role = SLOT_LOG_RD;
         default:            o_role = SLOT_HOST;
      endcase
   end

endmodule

// File: rtl/trb_mem_scheduler.sv
// Time-division arbiter of the single-port trace RAM between the
// Logger (write slot, read slot) and the host request/grant port.
module trb_mem_scheduler
   import dtb_pkg::*;
#(
   parameter int HOST_SLOTS = TRB_HOST_SLOTS
) (
   input  logic                      CLK_I,
   input  logic                      RST_NI,
   input  logic                      EN_I,
   output logic                      RW_TURN_O,
   output logic                      WRITE_ALLOW_O,
   output logic                      READ_ALLOW_O,
   input  logic                      LOG_WRITE_I,
   input  logic [TRB_ADDR_WIDTH-1:0] LOG_WPTR_I,
   input  logic [TRB_WIDTH-1:0]      LOG_WDATA_I,
   input  logic [TRB_ADDR_WIDTH-1:0] LOG_RPTR_I,
   output logic [TRB_WIDTH-1:0]      LOG_RDATA_O,
   input  logic                      HOST_REQ_I,
   input  logic                      HOST_WE_I,
   input  logic [TRB_ADDR_WIDTH-1:0] HOST_ADDR_I,
   input  logic [TRB_WIDTH-1:0]      HOST_WDATA_I,
   output logic                      HOST_GNT_O,
   output logic [TRB_WIDTH-1:0]      HOST_RDATA_O,
   output logic                      HOST_RVALID_O,
   output logic [TRB_ADDR_WIDTH-1:0] MEM_ADDR_O,
   output logic                      MEM_WE_O,
   output logic [TRB_WIDTH-1:0]      MEM_WDATA_O,
   input  logic [TRB_WIDTH-1:0]      MEM_RDATA_I
);

   localparam int NSLOT = 2 + HOST_SLOTS;

   slot_role_t           w_role;
   logic                 w_en;
   logic                 w_log_wr;
   logic                 w_log_rd;
   logic                 w_gnt;
   logic                 w_host_rd;
   logic [TRB_WIDTH-1:0] r_rdata;
   logic                 r_rvalid;

   trb_slot_counter #(
      .NSLOT (NSLOT)
   ) u_slot (
      .i_clk   (CLK_I),
      .i_rst_n (RST_NI),
      .o_role  (w_role)
   );

   // Gating with RST_NI keeps allows and grant low during reset.
   assign w_en      = EN_I & RST_NI;
   assign w_log_wr  = w_en & (w_role == SLOT_LOG_WR);
   assign w_log_rd  = w_en & (w_role == SLOT_LOG_RD);
   assign w_gnt     = RST_NI & HOST_REQ_I
                    & ((w_role == SLOT_HOST) | ~EN_I);
   assign w_host_rd = w_gnt & ~HOST_WE_I;

   assign RW_TURN_O     = (w_role == SLOT_LOG_WR);
   assign WRITE_ALLOW_O = w_log_wr;
   assign READ_ALLOW_O  = w_log_rd;
   assign HOST_GNT_O    = w_gnt;
   assign LOG_RDATA_O   = MEM_RDATA_I;
   assign HOST_RDATA_O  = r_rdata;
   assign HOST_RVALID_O = r_rvalid;

   always_comb begin
      MEM_ADDR_O  = '0;
      MEM_WE_O    = 1'b0;
      MEM_WDATA_O = '0;
      unique case (1'b1)
         w_log_wr: begin
            MEM_ADDR_O  = LOG_WPTR_I;
            MEM_WE_O    = LOG_WRITE_I;
            MEM_WDATA_O = LOG_WDATA_I;
         end
         w_log_rd: begin
            MEM_ADDR_O  = LOG_RPTR_I;
         end
         w_gnt: begin
            MEM_ADDR_O  = HOST_ADDR_I;
            MEM_WE_O    = HOST_WE_I;
            MEM_WDATA_O = HOST_WDATA_I;
         end
         default: begin
            MEM_ADDR_O  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= w_host_rd;
         if (w_host_rd) begin
            r_rdata <= MEM_RDATA_I;
         end
      end
   end

endmodule

// File: doc/trb_mem_scheduler.md
Name: trb_mem_scheduler

Overview:
Time-division scheduler for the single-port trace RAM shared by the Logger and the host-side system interface. Generates the Logger's RW_TURN strobe and its WRITE_ALLOW/READ_ALLOW gates. Grants the host request/grant access in dedicated slots and muxes address, write-enable and write data onto the RAM. Sits between the Logger, the interface and the memory macro.

Parameters:
HOST_SLOTS, 2, host slots per frame (1..6); frame length NSLOT = 2 + HOST_SLOTS.
TRB_WIDTH, package value, RAM word width.
TRB_ADDR_WIDTH, package value, RAM address width.

Ports:
CLK_I  in  1  clock
RST_NI  in  1  asynchronous active-low reset
EN_I  in  1  Logger access enable (0 = host owns every cycle)
RW_TURN_O  out  1  1 in the Logger write slot, 0 otherwise
WRITE_ALLOW_O  out  1  Logger may write this cycle
READ_ALLOW_O  out  1  Logger may read this cycle
LOG_WRITE_I  in  1  Logger write strobe (Logger WRITE_O)
LOG_WPTR_I  in  TRB_ADDR_WIDTH  Logger write pointer
LOG_WDATA_I  in  TRB_WIDTH  Logger write data
LOG_RPTR_I  in  TRB_ADDR_WIDTH  Logger read pointer
LOG_RDATA_O  out  TRB_WIDTH  RAM read data to Logger (pass-through)
HOST_REQ_I  in  1  host access request, held until grant
HOST_WE_I  in  1  1 = host write, 0 = host read
HOST_ADDR_I  in  TRB_ADDR_WIDTH  host address
HOST_WDATA_I  in  TRB_WIDTH  host write data
HOST_GNT_O  out  1  one-cycle grant; access executes this cycle
HOST_RDATA_O  out  TRB_WIDTH  registered host read data
HOST_RVALID_O  out  1  pulse, HOST_RDATA_O valid
MEM_ADDR_O  out  TRB_ADDR_WIDTH  RAM address
MEM_WE_O  out  1  RAM write enable
MEM_WDATA_O  out  TRB_WIDTH  RAM write data
MEM_RDATA_I  in  TRB_WIDTH  RAM read data (asynchronous read, writes on CLK_I edge)

Behaviour:
- Slot counter `slot`, width $clog2(NSLOT), advances +1 every cycle and wraps NSLOT-1 -> 0. It runs regardless of EN_I.
- Slot roles:
  - slot 0 = Logger write (RW_TURN_O=1).
  - slot 1 = Logger read (RW_TURN_O=0).
  - slots 2..NSLOT-1 = host (RW_TURN_O=0).
- Allow gates:
  - WRITE_ALLOW_O = EN_I && slot==0.
  - READ_ALLOW_O = EN_I && slot==1.
  - Both are combinational from the slot register and EN_I.
- Host-eligible cycle: slot>=2, or EN_I==0.
  - HOST_GNT_O = HOST_REQ_I && host-eligible.
  - A request held across consecutive eligible cycles is granted back-to-back.
- RAM mux by priority:
  1. Slot 0 with EN_I: MEM_ADDR_O=LOG_WPTR_I, MEM_WE_O=LOG_WRITE_I, MEM_WDATA_O=LOG_WDATA_I.
  2. Slot 1 with EN_I: MEM_ADDR_O=LOG_RPTR_I, MEM_WE_O=0.
  3. Host grant: MEM_ADDR_O=HOST_ADDR_I, MEM_WE_O=HOST_WE_I, MEM_WDATA_O=HOST_WDATA_I.
  4. Otherwise: MEM_ADDR_O=0, MEM_WE_O=0, MEM_WDATA_O=0.
- LOG_RDATA_O = MEM_RDATA_I at all times.
- Host read: on a grant with HOST_WE_I=0, HOST_RDATA_O <= MEM_RDATA_I at the clock edge. HOST_RVALID_O=1 for exactly the following cycle.
- Host write: no HOST_RVALID_O pulse.
- Worst-case host grant latency while EN_I=1 is 2 cycles (request raised in slot 0).
- EN_I falling mid-frame: allows drop in the same cycle. The slot counter is not reset. The host may be granted in slots 0/1 from that cycle on.
- LOG_WRITE_I outside slot 0, or with EN_I=0: ignored, MEM_WE_O=0.
- Async reset:
  - slot=0, HOST_RDATA_O=0, HOST_RVALID_O=0 immediately.
  - WRITE_ALLOW_O, READ_ALLOW_O and HOST_GNT_O are forced 0 while RST_NI=0, even if EN_I/HOST_REQ_I are high.
  - An in-flight host access is dropped: no RVALID after reset release. The host re-requests.
- First cycle after release: slot 0, RW_TURN_O=1.
- No address-collision checking. The host owns consistency with the Logger pointers.

Decomposition:
- DTB_PKG: TRB_WIDTH, TRB_ADDR_WIDTH (existing), plus new constant TRB_HOST_SLOTS (default 2).
- DTB_PKG also gets the enum slot_role_t {SLOT_LOG_WR, SLOT_LOG_RD, SLOT_HOST}.
- Sub-module trb_slot_counter: wrap counter emitting slot_role_t.
- Mux and host handshake stay in trb_mem_scheduler.

Test Plan:
1. Reset release, EN_I=1, HOST_SLOTS=2 -> RW_TURN_O=1,0,0,0 repeating; WRITE_ALLOW_O high at cycles 0,4,8; READ_ALLOW_O high at cycles 1,5,9.
2. HOST_REQ_I=1, WE=0, ADDR=0x05 raised in slot 0, mem[5]=0xDEAD -> HOST_GNT_O in slot 2 with MEM_ADDR_O=0x05; next cycle HOST_RVALID_O=1, HOST_RDATA_O=0xDEAD.
3. Slot 0, LOG_WRITE_I=1, LOG_WPTR_I=3, LOG_WDATA_I=0xAA, HOST_REQ_I=1 -> MEM_WE_O=1, MEM_ADDR_O=3, HOST_GNT_O=0; host granted in slot 2.
4. EN_I=0, host holds a read request for 4 cycles at addresses 0..3 -> 4 consecutive grants, 4 RVALID pulses; allows stay 0; LOG_WRITE_I=1 gives MEM_WE_O=0.
5. RST_NI asserted in a host read-grant cycle -> HOST_RVALID_O stays 0; outputs at reset values immediately; slot=0 after release.
6. HOST_SLOTS=1 -> frame period 3: RW_TURN_O=1,0,0; grant latency ≤2 cycles.
